// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with req/busy/ack handshake, configurable wait states,
// byte/half/word access with sign/zero extension, error responses and optional post-reset clear.

module data_memory_lane #(
    parameter int WORDS = 256,
    parameter int WAW   = 8
) (
    input  logic           clk_i,
    input  logic           we,
    input  logic [WAW-1:0] waddr,
    input  logic [7:0]     wdata,
    input  logic [WAW-1:0] raddr,
    output logic [7:0]     rdata
);
    logic [7:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2,
    parameter bit INIT_CLEAR  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int NUM_LANES = 4;
    localparam int WORDS     = DEPTH_BYTES / NUM_LANES;
    localparam int WAW       = $clog2(WORDS);
    localparam int AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0] LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    state_t   state_q, state_d;
    mem_req_t req_q, req_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [WAW-1:0] clr_q, clr_d;
    logic [31:0]    rdata_q;

    logic [1:0]                     off;
    logic [WAW-1:0]                 widx, waddr;
    logic                           err;
    logic [NUM_LANES-1:0]           be, lane_we;
    logic [NUM_LANES-1:0][7:0]      lane_wdata, lane_rdata;
    logic [31:0]                    rd_word, wd_sh, load_res;
    logic [15:0]                    rd_sh;

    assign off     = req_q.addr[1:0];
    assign widx    = req_q.addr[AW-1:2];
    assign rd_word = lane_rdata;
    assign wd_sh   = req_q.wdata << {off, 3'b000};
    assign rd_sh   = 16'(rd_word >> {off, 3'b000});
    assign waddr   = (state_q == ST_INIT) ? clr_q : widx;

    // Full 32-bit range check so high addresses never alias into the array.
    always_comb begin
        err = (req_q.addr >= 32'(DEPTH_BYTES));
        be  = '0;
        case (req_q.size)
            2'b00: be = 4'b0001 << off;
            2'b01: begin
                be = 4'b0011 << off;
                if (off[0]) err = 1'b1;
            end
            2'b10: begin
                be = 4'b1111;
                if (off != 2'b00) err = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        case (req_q.size)
            2'b00:   load_res = req_q.sign ? {{24{rd_sh[7]}}, rd_sh[7:0]} : {24'd0, rd_sh[7:0]};
            2'b01:   load_res = req_q.sign ? {{16{rd_sh[15]}}, rd_sh} : {16'd0, rd_sh};
            default: load_res = rd_word;
        endcase
        if (err || req_q.we) load_res = '0;
    end

    // Writes are gated by reset so an access abandoned in RESP never commits.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_we[k]    = !rst_i && ((state_q == ST_INIT) ||
                               (state_q == ST_RESP && req_q.we && !err && be[k]));
        assign lane_wdata[k] = (state_q == ST_INIT) ? 8'd0 : wd_sh[8*k +: 8];

        data_memory_lane #(.WORDS(WORDS), .WAW(WAW)) u_lane (
            .clk_i (clk_i),
            .we    (lane_we[k]),
            .waddr (waddr),
            .wdata (lane_wdata[k]),
            .raddr (widx),
            .rdata (lane_rdata[k])
        );
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        case (state_q)
            ST_INIT: begin
                clr_d = clr_q + WAW'(1);
                if (clr_q == WAW'(WORDS - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_i) begin
                    req_d   = '{we: we_i, size: size_i, sign: sign_i, addr: addr_i, wdata: wdata_i};
                    cnt_d   = '0;
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) state_d = ST_RESP;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT_CLEAR ? ST_INIT : ST_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            clr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            if (state_q == ST_RESP) rdata_q <= load_res;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign ack_o   = (state_q == ST_RESP);
    assign err_o   = ack_o && err;
    assign rdata_o = ack_o ? load_res : rdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (LATENCY=2/1024B and LATENCY=0/64B) driven
// with directed and random accesses, checked against a byte-array reference model.

module tb_data_memory_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, rst0, req2, req0, we, sign;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy2, ack2, err2, busy0, ack0, err0;
    logic [31:0] rdata2, rdata0;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mm [2][1024];

    data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(2), .INIT_CLEAR(1)) u_dut (
        .clk_i(clk), .rst_i(rst2), .req_i(req2), .we_i(we), .size_i(size), .sign_i(sign),
        .addr_i(addr), .wdata_i(wdata), .busy_o(busy2), .ack_o(ack2), .rdata_o(rdata2), .err_o(err2));

    data_memory_ctrl #(.DEPTH_BYTES(64), .LATENCY(0), .INIT_CLEAR(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .req_i(req0), .we_i(we), .size_i(size), .sign_i(sign),
        .addr_i(addr), .wdata_i(wdata), .busy_o(busy0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0));

    function automatic int dep(input int d); return d ? 64 : 1024; endfunction
    function automatic int lat(input int d); return d ? 0 : 2; endfunction
    function automatic logic o_busy(input int d); return d ? busy0 : busy2; endfunction
    function automatic logic o_ack(input int d); return d ? ack0 : ack2; endfunction
    function automatic logic o_err(input int d); return d ? err0 : err2; endfunction
    function automatic logic [31:0] o_rdata(input int d); return d ? rdata0 : rdata2; endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int d, input logic v);
        if (d != 0) req0 = v; else req2 = v;
    endtask

    task automatic set_rst(input int d, input logic v);
        if (d != 0) rst0 = v; else rst2 = v;
    endtask

    task automatic scramble();
        we    = 1'($urandom);
        size  = 2'($urandom);
        sign  = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // Called at a negedge; leaves the bench at a negedge with the DUT idle.
    task automatic reset_dut(input int d);
        int n;
        set_rst(d, 1'b1);
        set_req(d, 1'b0);
        @(negedge clk);
        chk("rst_busy", 32'(o_busy(d)), 32'd1);
        chk("rst_ack", 32'(o_ack(d)), 32'd0);
        chk("rst_err", 32'(o_err(d)), 32'd0);
        chk("rst_rdata", o_rdata(d), 32'd0);
        set_rst(d, 1'b0);
        n = 0;
        while (o_busy(d) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("init_len", 32'(n), 32'(dep(d) / 4));
        for (int i = 0; i < 1024; i++) mm[d][i] = 8'd0;
    endtask

    task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rd);
        int n, first;
        bit e;
        logic [31:0] ex, got_rd;
        logic got_err;
        n = 1 << sz;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
            (a >= 32'(dep(d)));
        ex = '0;
        if (!e && !w) begin
            for (int i = 0; i < n; i++) ex = ex | (32'(mm[d][int'(a) + i]) << (8 * i));
            if (sg && n < 4 && ex[8*n-1]) ex = ex | ~((32'd1 << (8 * n)) - 32'd1);
        end
        if (!e && w) for (int i = 0; i < n; i++) mm[d][int'(a) + i] = 8'(wd >> (8 * i));

        we = w; size = sz; sign = sg; addr = a; wdata = wd;
        set_req(d, 1'b1);
        chk("idle_in", 32'(o_busy(d)), 32'd0);
        @(posedge clk);
        #1;
        scramble();
        if (!hold) set_req(d, 1'b0);
        first = -1;
        got_rd = '0;
        got_err = 1'b0;
        for (int c = 1; c <= lat(d) + 2; c++) begin
            @(negedge clk);
            if (o_ack(d) && first < 0) begin
                first = c;
                got_rd = o_rdata(d);
                got_err = o_err(d);
            end
            if (hold) scramble();
        end
        chk("ack_lat", 32'(first), 32'(lat(d) + 1));
        chk("err", 32'(got_err), 32'(e));
        if (e || !w) chk("rdata", got_rd, ex);
        chk("busy_end", 32'(o_busy(d)), 32'd0);
        chk("ack_end", 32'(o_ack(d)), 32'd0);
        if (e || !w) chk("rdata_hold", o_rdata(d), ex);
        rd = got_rd;
    endtask

    task automatic rnd_access(input int d);
        logic [1:0] sz;
        logic [31:0] a, rd;
        int r, r2;
        r  = int'($urandom % 16);
        sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
        r2 = int'($urandom % 16);
        if (r2 == 0)      a = 32'(dep(d)) + ($urandom % 8);
        else if (r2 == 1) a = $urandom;
        else if (r2 == 2) a = 32'(dep(d) - 4);
        else              a = $urandom % 32'(dep(d));
        if (r2 >= 2 && r2 < 13 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
        access(d, 1'($urandom), sz, 1'($urandom), a, $urandom, ($urandom % 4) == 0, rd);
    endtask

    logic [31:0] rd;
    logic [31:0] t2_exp [4];

    initial begin
        rst2 = 1'b1; rst0 = 1'b1; req2 = 1'b0; req0 = 1'b0;
        we = 1'b0; size = 2'd0; sign = 1'b0; addr = '0; wdata = '0;
        t2_exp = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
        repeat (2) @(negedge clk);
        reset_dut(1);
        reset_dut(0);

        access(0, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 1'b0, rd);
        chk("t1_ld3fc", rd, 32'h0);

        access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd);
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b0, 2'd0, 1'b0, 32'h10 + 32'(i), 32'h0, 1'b0, rd);
            chk("t2_byte", rd, t2_exp[i]);
        end

        access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0000807F, 1'b0, rd);
        access(0, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 1'b0, rd);
        chk("t3_b20s", rd, 32'h0000007F);
        access(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b0, rd);
        chk("t3_b21s", rd, 32'hFFFFFF80);
        access(0, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b0, rd);
        chk("t3_h20u", rd, 32'h0000807F);
        access(0, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 1'b0, rd);
        chk("t3_h20s", rd, 32'hFFFF807F);

        access(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 1'b0, rd);
        access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd);
        chk("t4_w20", rd, 32'h0000807F);
        access(0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, rd);
        access(0, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b0, rd);
        access(0, 1'b1, 2'd2, 1'b0, 32'h3FC, 32'hA5001234, 1'b0, rd);
        access(0, 1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0, 1'b0, rd);
        chk("t4_b3ff", rd, 32'hFFFFFFA5);

        access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, rd);
        access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd);
        access(1, 1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D, 1'b1, rd);
        access(1, 1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 1'b0, rd);
        chk("t5_h0a", rd, 32'hFFFFCAFE);

        repeat (300) rnd_access(0);
        set_req(0, 1'b0);
        repeat (200) rnd_access(1);
        set_req(1, 1'b0);

        we = 1'b1; size = 2'd2; sign = 1'b0; addr = 32'h40; wdata = 32'h12345678;
        req2 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0;
        @(negedge clk);
        chk("t6_wait", 32'(ack2), 32'd0);
        reset_dut(0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, rd);
        chk("t6_w40", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
